// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: one outstanding read, squash of wrong-path
// responses, and a bounded wait that substitutes a NOP and flags a bus error.
module imem_fetch_ctrl #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_fetch_req,
   input  logic [31:0] i_fetch_addr,
   input  logic        i_redirect,
   input  logic        i_de_stall,
   output logic        o_if_stall,
   output logic [31:0] o_instr_out,
   output logic        o_instr_valid,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_bus_err,
   output logic [7:0]  o_err_count
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_WAIT_GNT  = 2'd1;
   localparam logic [1:0] S_WAIT_DATA = 2'd2;
   localparam logic [1:0] S_HOLD      = 2'd3;
   localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 32'd1);

   logic [1:0]  r_state;
   logic        r_mem_req;
   logic [31:0] r_mem_addr;
   logic [31:0] r_instr_out;
   logic        r_instr_valid;
   logic        r_bus_err;
   logic [7:0]  r_err_count;
   logic        r_squash;
   logic [7:0]  r_wait_cnt;

   logic [1:0]  w_state_nxt;
   logic        w_mem_req_nxt;
   logic [31:0] w_mem_addr_nxt;
   logic [31:0] w_instr_nxt;
   logic        w_valid_nxt;
   logic        w_bus_err_nxt;
   logic [7:0]  w_err_count_nxt;
   logic        w_squash_nxt;
   logic [7:0]  w_wait_cnt_nxt;
   logic        w_in_wait;
   logic        w_in_wait_nxt;
   logic        w_squash_eff;
   logic        w_tmo_hit;
   logic        w_timeout;

   // Next-state and datapath decode for the fetch FSM
   always_comb begin
      w_state_nxt     = r_state;
      w_mem_req_nxt   = r_mem_req;
      w_mem_addr_nxt  = r_mem_addr;
      w_instr_nxt     = r_instr_out;
      w_valid_nxt     = r_instr_valid;
      w_bus_err_nxt   = 1'b0;
      w_err_count_nxt = r_err_count;
      w_timeout       = 1'b0;
      w_in_wait       = (r_state == S_WAIT_GNT) || (r_state == S_WAIT_DATA);
      w_squash_eff    = r_squash | i_redirect;
      w_tmo_hit       = (r_wait_cnt == TMO_LAST);

      case (r_state)
         S_IDLE: begin
            if (i_fetch_req) begin
               w_mem_addr_nxt = i_fetch_addr;
               w_mem_req_nxt  = 1'b1;
               w_state_nxt    = S_WAIT_GNT;
            end else begin
               w_state_nxt    = S_IDLE;
            end
         end
         S_WAIT_GNT: begin
            // The wait budget wins over a grant arriving on the very last cycle
            if (w_tmo_hit) begin
               w_timeout     = 1'b1;
            end else if (i_mem_gnt) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = S_WAIT_DATA;
            end else begin
               w_state_nxt   = S_WAIT_GNT;
            end
         end
         S_WAIT_DATA: begin
            if (i_mem_rvalid) begin
               if (w_squash_eff) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_instr_nxt = i_mem_rdata;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end else if (w_tmo_hit) begin
               w_timeout   = 1'b1;
            end else begin
               w_state_nxt = S_WAIT_DATA;
            end
         end
         S_HOLD: begin
            if (!i_de_stall || i_redirect) begin
               w_valid_nxt = 1'b0;
               if (i_fetch_req) begin
                  w_mem_addr_nxt = i_fetch_addr;
                  w_mem_req_nxt  = 1'b1;
                  w_state_nxt    = S_WAIT_GNT;
               end else begin
                  w_state_nxt    = S_IDLE;
               end
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
            w_valid_nxt   = 1'b0;
         end
      endcase

      if (w_timeout) begin
         w_mem_req_nxt   = 1'b0;
         w_bus_err_nxt   = 1'b1;
         w_err_count_nxt = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
         if (w_squash_eff) begin
            w_state_nxt = S_IDLE;
         end else begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
         end
      end else begin
         w_bus_err_nxt = 1'b0;
      end

      w_in_wait_nxt  = (w_state_nxt == S_WAIT_GNT) || (w_state_nxt == S_WAIT_DATA);
      w_squash_nxt   = w_in_wait_nxt ? (r_squash | (w_in_wait & i_redirect)) : 1'b0;
      w_wait_cnt_nxt = (w_in_wait && w_in_wait_nxt) ? r_wait_cnt + 8'd1 : 8'd0;
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= 32'd0;
         r_instr_out   <= 32'd0;
         r_instr_valid <= 1'b0;
         r_bus_err     <= 1'b0;
         r_err_count   <= 8'd0;
         r_squash      <= 1'b0;
         r_wait_cnt    <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_mem_req     <= w_mem_req_nxt;
         r_mem_addr    <= w_mem_addr_nxt;
         r_instr_out   <= w_instr_nxt;
         r_instr_valid <= w_valid_nxt;
         r_bus_err     <= w_bus_err_nxt;
         r_err_count   <= w_err_count_nxt;
         r_squash      <= w_squash_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
      end
   end

   assign o_if_stall    = ~(r_instr_valid & ~i_de_stall);
   assign o_instr_out   = r_instr_out;
   assign o_instr_valid = r_instr_valid;
   assign o_mem_req     = r_mem_req;
   assign o_mem_addr    = r_mem_addr;
   assign o_bus_err     = r_bus_err;
   assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a transaction-level reference model.
module tb_imem_fetch_ctrl;

   localparam int          T   = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_fr, s_rd, s_ds, s_gnt, s_rv;
   logic [31:0] s_fa, s_rdata;
   logic        if_stall, instr_valid, mem_req, bus_err;
   logic [31:0] instr_out, mem_addr;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: a request is either outstanding (busy) or an instruction is held
   logic        m_busy, m_granted, m_squash, m_valid, m_req, m_bus_err;
   logic [31:0] m_instr, m_addr;
   int          m_age, m_errs;

   imem_fetch_ctrl #(.TIMEOUT(T), .NOP_INSTR(NOP)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_fetch_req(s_fr), .i_fetch_addr(s_fa), .i_redirect(s_rd), .i_de_stall(s_ds),
      .o_if_stall(if_stall), .o_instr_out(instr_out), .o_instr_valid(instr_valid),
      .o_mem_req(mem_req), .o_mem_addr(mem_addr),
      .i_mem_gnt(s_gnt), .i_mem_rvalid(s_rv), .i_mem_rdata(s_rdata),
      .o_bus_err(bus_err), .o_err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_granted = 0; m_squash = 0; m_valid = 0; m_req = 0; m_bus_err = 0;
      m_instr = 32'd0; m_addr = 32'd0; m_age = 0; m_errs = 0;
   endtask

   task automatic model_issue();
      m_addr = s_fa; m_req = 1'b1; m_busy = 1'b1; m_granted = 1'b0; m_age = 0;
   endtask

   task automatic model_step();
      logic sq, leave;
      m_bus_err = 1'b0;
      if (m_busy) begin
         sq    = m_squash | s_rd;
         leave = 1'b0;
         if (m_granted && s_rv) begin
            leave = 1'b1;
            if (!sq) begin m_instr = s_rdata; m_valid = 1'b1; end
         end else if (m_age == T - 1) begin
            leave = 1'b1; m_req = 1'b0; m_bus_err = 1'b1;
            if (m_errs < 255) m_errs++;
            if (!sq) begin m_instr = NOP; m_valid = 1'b1; end
         end else begin
            if (!m_granted && s_gnt) begin m_granted = 1'b1; m_req = 1'b0; end
            m_age++;
            m_squash = sq;
         end
         if (leave) begin m_busy = 0; m_granted = 0; m_age = 0; m_squash = 0; end
      end else if (m_valid) begin
         if (!s_ds || s_rd) begin
            m_valid = 1'b0;
            if (s_fr) model_issue();
         end
      end else if (s_fr) begin
         model_issue();
      end
   endtask

   task automatic check_all();
      check_eq("mem_req",     32'(mem_req),     32'(m_req));
      check_eq("mem_addr",    mem_addr,         m_addr);
      check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
      check_eq("instr_out",   instr_out,        m_instr);
      check_eq("bus_err",     32'(bus_err),     32'(m_bus_err));
      check_eq("err_count",   32'(err_count),   32'(m_errs));
      check_eq("if_stall",    32'(if_stall),    32'(!(m_valid && !s_ds)));
   endtask

   task automatic set_in(input logic fr, input logic [31:0] fa, input logic rd, input logic ds,
                         input logic gnt, input logic rv, input logic [31:0] rdata);
      s_fr = fr; s_fa = fa; s_rd = rd; s_ds = ds; s_gnt = gnt; s_rv = rv; s_rdata = rdata;
   endtask

   // one clock: inputs already driven, model follows the edge, outputs checked at negedge
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 32'd0, 0, 0, 0, 0, 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // basic fetch at minimum latency
      set_in(1, 32'h100, 0, 0, 0, 0, 32'd0); step();
      check_eq("lat_mem_req", 32'(mem_req), 32'd1);
      check_eq("lat_mem_addr", mem_addr, 32'h100);
      set_in(0, 32'h0, 0, 0, 1, 0, 32'd0); step();
      set_in(0, 32'h0, 0, 0, 0, 1, 32'h00A0_0093); step();
      check_eq("basic_instr", instr_out, 32'h00A0_0093);
      check_eq("basic_valid", 32'(instr_valid), 32'd1);
      check_eq("basic_if_stall", 32'(if_stall), 32'd0);

      // decode stall holds the instruction
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'h104, 0, 1, 0, 0, 32'd0); step();
         check_eq("stall_valid", 32'(instr_valid), 32'd1);
         check_eq("stall_instr", instr_out, 32'h00A0_0093);
         check_eq("stall_if_stall", 32'(if_stall), 32'd1);
         check_eq("stall_no_req", 32'(mem_req), 32'd0);
      end
      set_in(1, 32'h104, 0, 0, 0, 0, 32'd0); step();
      check_eq("reissue_req", 32'(mem_req), 32'd1);
      check_eq("reissue_addr", mem_addr, 32'h104);

      // squash: redirect while waiting for grant
      set_in(0, 32'h0, 1, 0, 0, 0, 32'd0); step();
      check_eq("squash_hold_req", 32'(mem_req), 32'd1);
      set_in(0, 32'h0, 0, 0, 1, 0, 32'd0); step();
      set_in(0, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF); step();
      check_eq("squash_no_valid", 32'(instr_valid), 32'd0);
      set_in(1, 32'h200, 0, 0, 0, 0, 32'd0); step();
      check_eq("squash_new_addr", mem_addr, 32'h200);

      // timeout with no grant
      for (int i = 0; i < T - 1; i++) begin
         set_in(0, 32'h0, 0, 1, 0, 0, 32'd0); step();
         check_eq("tmo_req_high", 32'(mem_req), 32'd1);
      end
      step();
      check_eq("tmo_req_low", 32'(mem_req), 32'd0);
      check_eq("tmo_bus_err", 32'(bus_err), 32'd1);
      check_eq("tmo_nop", instr_out, NOP);
      check_eq("tmo_err_count", 32'(err_count), 32'd1);
      set_in(0, 32'h0, 0, 1, 0, 1, 32'h1234_5678); step();
      check_eq("tmo_pulse_end", 32'(bus_err), 32'd0);
      check_eq("late_rvalid_instr", instr_out, NOP);
      set_in(0, 32'h0, 0, 0, 0, 0, 32'd0); step();

      // asynchronous reset while waiting for data
      set_in(1, 32'h300, 0, 0, 0, 0, 32'd0); step();
      set_in(0, 32'h0, 0, 0, 1, 0, 32'd0); step();
      set_in(0, 32'h0, 0, 0, 0, 0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_mem_req", 32'(mem_req), 32'd0);
      check_eq("arst_mem_addr", mem_addr, 32'd0);
      check_eq("arst_valid", 32'(instr_valid), 32'd0);
      check_eq("arst_instr", instr_out, 32'd0);
      check_eq("arst_err_count", 32'(err_count), 32'd0);
      check_eq("arst_bus_err", 32'(bus_err), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      set_in(0, 32'h0, 0, 0, 0, 1, 32'hCAFE_F00D); step();
      check_eq("arst_late_rvalid", 32'(instr_valid), 32'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         set_in($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 4) < 2, $urandom_range(0, 19) < 7, $urandom);
         step();
      end

      // saturation: back-to-back timeouts
      for (int i = 0; i < 3000; i++) begin
         set_in(1, 32'h400, 0, 0, 0, 0, 32'd0); step();
      end
      check_eq("sat_err_count", 32'(err_count), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
